// File: rtl/alu_modos_pkg.sv
// alu_modos_pkg: shared op/state encodings and 7-segment decode for the ALU mode selector.
package alu_modos_pkg;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL
    } op_e;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
    localparam logic [6:0] SEG_BLANK = 7'h7f;
    // segments gfedcba, active-low
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e
    };
    function automatic logic [6:0] hex7(input logic [3:0] h);
        return SEG_LUT[h];
    endfunction
endpackage

// File: rtl/alu_modos_seq_if.sv
// alu_modos_seq_if: board-side keys, switches, results and display segments of the ALU.
interface alu_modos_seq_if #(parameter int N = 4);
    logic selector, start;
    logic [N-1:0] a, b, result;
    logic [3:0] op;
    logic flag_n, flag_z, flag_c, flag_v, valid, done;
    logic [6:0] display1, display2, display3, display4, display5, display6;
    modport master (
        output selector, start, a, b,
        input op, result, flag_n, flag_z, flag_c, flag_v, valid, done,
        input display1, display2, display3, display4, display5, display6
    );
    modport slave (
        input selector, start, a, b,
        output op, result, flag_n, flag_z, flag_c, flag_v, valid, done,
        output display1, display2, display3, display4, display5, display6
    );
endinterface

// File: rtl/alu_modos_seq_key_conditioner.sv
// key_conditioner: synchronises and debounces an active-low key, pulsing once per accepted press.
module key_conditioner #(parameter int DEBOUNCE = 50000) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    logic [1:0] sync;
    logic level, flip, hit;
    logic [CW-1:0] cnt;
    assign flip = sync[1] != level;
    assign hit = flip && cnt == CW'(DEBOUNCE - 1);
    // a new level is accepted only after DEBOUNCE consecutive differing samples
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync <= 2'b11;
            level <= 1'b1;
            cnt <= '0;
            press <= 1'b0;
        end else begin
            sync <= {sync[0], key_n};
            cnt <= (flip && !hit) ? cnt + 1'b1 : '0;
            level <= hit ? sync[1] : level;
            press <= hit && !sync[1];
        end
endmodule

// File: rtl/alu_modos_seq.sv
// alu_modos_seq: key-driven op selector and single-cycle ALU with registered result, flags
// and active-low 7-segment displays.
module alu_modos_seq import alu_modos_pkg::*; #(
    parameter int N = 4,
    parameter int NUM_OPS = 10,
    parameter int DEBOUNCE = 50000
) (
    input logic clk,
    input logic rst_n,
    alu_modos_seq_if.slave bus
);
    logic sel_p, start_p, latch, adv, done_q;
    logic fn, fz, fc, fv, alu_c, alu_v;
    logic [3:0] op;
    logic [N-1:0] ra, rb, res, alu_r;
    logic [N:0] sum, dif;
    logic [2*N-1:0] prod;
    logic [7:0] rx;
    state_e state, state_d;
    key_conditioner #(.DEBOUNCE(DEBOUNCE)) u_sel (.clk, .rst_n, .key_n(bus.selector), .press(sel_p));
    key_conditioner #(.DEBOUNCE(DEBOUNCE)) u_start (.clk, .rst_n, .key_n(bus.start), .press(start_p));
    // start beats a simultaneous selector press; both are ignored while executing
    always_comb begin
        latch = start_p && state != S_EXEC;
        adv = sel_p && !start_p && state != S_EXEC;
        state_d = latch ? S_EXEC : state == S_EXEC ? S_DONE : adv ? S_IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else state <= state_d;
    always_comb begin
        sum = {1'b0, ra} + {1'b0, rb};
        dif = {1'b0, ra} - {1'b0, rb};
        prod = {{N{1'b0}}, ra} * {{N{1'b0}}, rb};
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op)
            OP_ADD: begin
                alu_r = sum[N-1:0];
                alu_c = sum[N];
                alu_v = ra[N-1] == rb[N-1] && sum[N-1] != ra[N-1];
            end
            OP_SUB: begin
                alu_r = dif[N-1:0];
                alu_c = !dif[N];
                alu_v = ra[N-1] != rb[N-1] && dif[N-1] != ra[N-1];
            end
            OP_MUL: begin
                alu_r = prod[N-1:0];
                alu_v = |prod[2*N-1:N];
            end
            OP_DIV: begin
                alu_r = rb == '0 ? '1 : ra / rb;
                alu_v = rb == '0;
            end
            OP_MOD: begin
                alu_r = rb == '0 ? '1 : ra % rb;
                alu_v = rb == '0;
            end
            OP_AND: alu_r = ra & rb;
            OP_OR:  alu_r = ra | rb;
            OP_XOR: alu_r = ra ^ rb;
            OP_SLL: alu_r = ra << rb;
            OP_SRL: alu_r = ra >> rb;
            default: alu_r = '0;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            op <= '0;
            ra <= '0;
            rb <= '0;
            res <= '0;
            {fn, fz, fc, fv} <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= state == S_EXEC;
            if (latch) {ra, rb} <= {bus.a, bus.b};
            if (adv) op <= op == 4'(NUM_OPS - 1) ? '0 : op + 1'b1;
            if (state == S_EXEC) begin
                res <= alu_r;
                {fn, fz, fc, fv} <= {alu_r[N-1], alu_r == '0, alu_c, alu_v};
            end
        end
    assign rx = 8'(res);
    assign bus.op = op;
    assign bus.result = res;
    assign {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v} = {fn, fz, fc, fv};
    assign bus.valid = state == S_DONE;
    assign bus.done = done_q;
    assign bus.display1 = hex7(rx[3:0]);
    assign bus.display2 = N <= 4 ? SEG_BLANK : hex7(rx[7:4]);
    assign bus.display3 = hex7(op);
    assign bus.display4 = hex7({3'b0, fn});
    assign bus.display5 = hex7({3'b0, fz});
    assign bus.display6 = hex7({3'b0, fc});
endmodule

// File: tb/tb_alu_modos_seq.sv
// tb_alu_modos_seq: directed key/operand stimulus checked against an arithmetic model of the ALU
// plus literal expectations.
module tb_alu_modos_seq;
    localparam int N = 4;
    localparam int M = 1 << N;
    localparam int D = 2;
    localparam int H = D + 10;
    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e
    };
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic prev_done = 1'b0;
    int checks = 0, errors = 0, cyc = 0, pend = -1000, done_cnt = 0, exp_op = 0;
    always #5 clk = ~clk;
    alu_modos_seq_if #(.N(N)) bus ();
    alu_modos_seq #(.N(N), .NUM_OPS(10), .DEBOUNCE(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int sx(input int x);
        return x >= M / 2 ? x - M : x;
    endfunction

    // returns result and packed {n,z,c,v}
    function automatic void model(input int o, input int x, input int y, output int r, output int f);
        int s, c, v;
        r = 0; c = 0; v = 0;
        case (o)
            0: begin s = x + y; r = s % M; c = int'(s >= M); s = sx(x) + sx(y); v = int'(s >= M / 2 || s < -M / 2); end
            1: begin r = (x - y + M) % M; c = int'(x >= y); s = sx(x) - sx(y); v = int'(s >= M / 2 || s < -M / 2); end
            2: begin r = (x * y) % M; v = int'(x * y >= M); end
            3: begin r = y == 0 ? M - 1 : x / y; v = int'(y == 0); end
            4: begin r = y == 0 ? M - 1 : x % y; v = int'(y == 0); end
            5: r = x & y;
            6: r = x | y;
            7: r = x ^ y;
            8: r = y >= N ? 0 : (x << y) % M;
            9: r = y >= N ? 0 : x >> y;
            default: r = 0;
        endcase
        f = 8 * int'(r >= M / 2) + 4 * int'(r == 0) + 2 * c + v;
    endfunction

    always @(negedge clk) begin
        int r, f;
        cyc++;
        if (!rst_n) begin
            pend = -1000;
            chk("reset_outputs", longint'({bus.op, bus.result, bus.flag_n, bus.flag_z, bus.flag_c,
                bus.flag_v, bus.valid, bus.done}), 0);
        end else begin
            chk("displays", longint'({bus.display1, bus.display2, bus.display3, bus.display4,
                bus.display5, bus.display6}), longint'({SEG[bus.result], 7'h7f, SEG[bus.op],
                SEG[{3'b0, bus.flag_n}], SEG[{3'b0, bus.flag_z}], SEG[{3'b0, bus.flag_c}]}));
            if (dut.start_p) pend = cyc;
            if (bus.done) begin
                done_cnt++;
                model(exp_op, int'(bus.a), int'(bus.b), r, f);
                chk("done_single_cycle", longint'(prev_done), 0);
                chk("valid_with_done", longint'(bus.valid), 1);
                chk("start_to_done_latency", longint'(cyc - pend), 2);
                chk("model_result", longint'(bus.result), longint'(r));
                chk("model_flags", longint'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), longint'(f));
            end
        end
        prev_done = bus.done;
    end

    task automatic press(input bit s, input bit t);
        @(negedge clk);
        bus.selector = !s;
        bus.start = !t;
        repeat (H) @(negedge clk);
        bus.selector = 1'b1;
        bus.start = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic goto_op(input int tgt);
        for (int i = 0; i < 10 && exp_op != tgt; i++) begin
            press(1, 0);
            exp_op = (exp_op + 1) % 10;
        end
        chk("goto_op", longint'(bus.op), longint'(tgt));
    endtask

    task automatic run(input int o, input int x, input int y, input int r, input int f);
        int d0;
        goto_op(o);
        bus.a = 4'(x);
        bus.b = 4'(y);
        d0 = done_cnt;
        press(0, 1);
        chk("one_done_per_press", longint'(done_cnt - d0), 1);
        chk("op_kept", longint'(bus.op), longint'(o));
        chk("valid_held", longint'(bus.valid), 1);
        chk("literal_result", longint'(bus.result), longint'(r));
        chk("literal_flags", longint'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), longint'(f));
    endtask

    initial begin
        int d0;
        bus.selector = 1'b1;
        bus.start = 1'b1;
        bus.a = '0;
        bus.b = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_op", longint'(bus.op), 0);
        chk("rst_result", longint'(bus.result), 0);
        chk("rst_valid", longint'(bus.valid), 0);
        chk("rst_display3", longint'(bus.display3), longint'(7'b1000000));
        chk("rst_display2", longint'(bus.display2), longint'(7'b1111111));
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        bus.selector = 1'b0;
        @(negedge clk);
        bus.selector = 1'b1;
        repeat (10) @(negedge clk);
        chk("glitch_ignored", longint'(bus.op), 0);
        for (int i = 1; i <= 10; i++) begin
            press(1, 0);
            exp_op = i % 10;
            chk("op_step", longint'(bus.op), longint'(exp_op));
        end
        run(0, 7, 9, 0, 6);
        run(1, 3, 5, 14, 8);
        run(1, 8, 1, 7, 3);
        run(3, 9, 0, 15, 9);
        run(8, 1, 5, 0, 4);
        run(9, 12, 2, 3, 0);
        run(2, 5, 4, 4, 1);
        run(4, 9, 4, 1, 0);
        run(7, 12, 10, 6, 0);
        press(1, 0);
        exp_op = 8;
        chk("sel_leaves_done", longint'(bus.valid), 0);
        chk("sel_advances_op", longint'(bus.op), 8);
        bus.a = 4'd1;
        bus.b = 4'd2;
        d0 = done_cnt;
        press(1, 1);
        chk("both_executes", longint'(done_cnt - d0), 1);
        chk("both_op_unchanged", longint'(bus.op), 8);
        chk("both_result", longint'(bus.result), 4);
        bus.a = 4'd3;
        bus.b = 4'd1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 40 && !dut.start_p; i++) @(negedge clk);
        chk("start_pulse_seen", longint'(dut.start_p), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        bus.start = 1'b1;
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        chk("midexec_rst_result", longint'(bus.result), 0);
        chk("midexec_rst_op", longint'(bus.op), 0);
        #2 rst_n = 1'b1;
        exp_op = 0;
        repeat (H) @(negedge clk);
        chk("midexec_no_done", longint'(done_cnt - d0), 0);
        chk("midexec_valid", longint'(bus.valid), 0);
        chk("midexec_result_after", longint'(bus.result), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
